// File: rtl/ucode_store_loader.sv
// Microcode store writer: streams DEPTH words in, verifies a trailing XOR checksum,
// and releases the sequencer (Run) only after a verified load. The store is read combinationally.
module ucode_store_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WORD_W = 12
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Wr_Valid,
  input  logic [WORD_W-1:0] Wr_Data,
  output logic              Wr_Ready,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [WORD_W-1:0] Rd_Data,
  output logic              Run,
  output logic              Busy,
  output logic              Error,
  output logic [ADDR_W:0]   Word_Count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              store_we;
  logic              xfer;
  logic [WORD_W-1:0] store_q [DEPTH];

  assign Wr_Ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign xfer     = Wr_Valid && Wr_Ready;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      csum_q  <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // Start outranks everything, including a coincident transfer.
  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (xfer && count_q == LAST_IDX) state_d = S_CHECK;
        S_CHECK: if (xfer) state_d = (Wr_Data == csum_q) ? S_DONE : S_ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  // Status flags are derived from the next state so they are registered alongside it.
  always_comb begin
    count_d  = count_q;
    csum_d   = csum_q;
    store_we = 1'b0;
    if (Start) begin
      count_d = '0;
      csum_d  = '0;
    end else if (state_q == S_LOAD && xfer) begin
      store_we = 1'b1;
      count_d  = count_q + CNT_W'(1);
      csum_d   = csum_q ^ Wr_Data;
    end
    run_d   = (state_d == S_DONE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge Clock) begin
    if (store_we) store_q[count_q[ADDR_W-1:0]] <= Wr_Data;
  end

  assign Rd_Data    = run_q ? store_q[Rd_Addr] : '0;
  assign Run        = run_q;
  assign Busy       = busy_q;
  assign Error      = error_q;
  assign Word_Count = count_q;

endmodule

// File: tb/tb_ucode_store_loader.sv
// Randomized bench for ucode_store_loader: a transaction-level model of the load
// protocol is compared against the DUT every cycle, plus literal spot checks.
module tb_ucode_store_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int WORD_W = 12;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic              Wr_Valid = 1'b0;
  logic [WORD_W-1:0] Wr_Data = '0;
  logic              Wr_Ready;
  logic [ADDR_W-1:0] Rd_Addr = '0;
  logic [WORD_W-1:0] Rd_Data;
  logic              Run, Busy, Error;
  logic [ADDR_W:0]   Word_Count;

  ucode_store_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Wr_Valid(Wr_Valid),
    .Wr_Data(Wr_Data), .Wr_Ready(Wr_Ready), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
    .Run(Run), .Busy(Busy), .Error(Error), .Word_Count(Word_Count)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a load is "busy" until DEPTH words plus one checksum word have been taken.
  int unsigned       m_count;
  logic [WORD_W-1:0] m_csum;
  logic [WORD_W-1:0] m_store [DEPTH];
  bit                m_run, m_busy, m_err;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_count = 0; m_csum = '0; m_run = 0; m_busy = 0; m_err = 0;
    end else if (Start) begin
      m_count = 0; m_csum = '0; m_run = 0; m_busy = 1; m_err = 0;
    end else if (m_busy && Wr_Valid) begin
      if (m_count < DEPTH) begin
        m_store[m_count] = Wr_Data;
        m_csum = m_csum ^ Wr_Data;
        m_count++;
      end else begin
        m_busy = 0;
        if (Wr_Data == m_csum) m_run = 1;
        else m_err = 1;
      end
    end
  end

  always @(negedge Clock) begin
    chk("wr_ready", 32'(Wr_Ready), 32'(m_busy));
    chk("busy", 32'(Busy), 32'(m_busy));
    chk("run", 32'(Run), 32'(m_run));
    chk("error", 32'(Error), 32'(m_err));
    chk("word_count", 32'(Word_Count), m_count);
    chk("rd_data", 32'(Rd_Data), m_run ? 32'(m_store[Rd_Addr]) : 32'd0);
  end

  task automatic tick();
    @(posedge Clock);
    #2;
    Rd_Addr = ADDR_W'($urandom_range(DEPTH - 1));
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Present one word and hold it until it is accepted, with optional idle cycles first.
  task automatic push(input logic [WORD_W-1:0] d, input int gap_pct);
    int budget;
    logic rdy;
    while ($urandom_range(99) < gap_pct) begin
      Wr_Valid = 1'b0;
      Wr_Data  = WORD_W'($urandom);
      tick();
    end
    Wr_Valid = 1'b1;
    Wr_Data  = d;
    budget = 50;
    do begin
      rdy = Wr_Ready;
      tick();
      budget--;
    end while (!rdy && budget > 0);
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
    Wr_Valid = 1'b0;
  endtask

  task automatic load_image(input logic [WORD_W-1:0] img [DEPTH], input logic [WORD_W-1:0] cs,
                            input int gap_pct);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) push(img[i], gap_pct);
    push(cs, gap_pct);
  endtask

  function automatic logic [WORD_W-1:0] xor_of(input logic [WORD_W-1:0] img [DEPTH]);
    logic [WORD_W-1:0] x = '0;
    for (int i = 0; i < DEPTH; i++) x ^= img[i];
    return x;
  endfunction

  task automatic sweep_literal(input logic [WORD_W-1:0] img [DEPTH], input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      Rd_Addr = ADDR_W'(a);
      #1;
      chk(nm, 32'(Rd_Data), 32'(img[a]));
    end
  endtask

  logic [WORD_W-1:0] img_a [DEPTH];
  logic [WORD_W-1:0] img_b [DEPTH];
  logic [WORD_W-1:0] zeros [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      img_a[i] = WORD_W'(i + 1);
      img_b[i] = (i % 2 == 0) ? 12'hA5A : 12'h5A5;
      zeros[i] = '0;
    end

    repeat (2) tick();
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_count", 32'(Word_Count), 32'd0);
    Reset = 1'b1;
    tick();

    // Back-to-back load of 1..8 with checksum 0x008.
    load_image(img_a, 12'h008, 0);
    chk("done_run", 32'(Run), 32'd1);
    chk("done_busy", 32'(Busy), 32'd0);
    chk("done_count", 32'(Word_Count), 32'd8);
    sweep_literal(img_a, "sweep_a");

    // Bad checksum leaves the store locked out.
    load_image(img_a, 12'h009, 0);
    chk("err_flag", 32'(Error), 32'd1);
    chk("err_run", 32'(Run), 32'd0);
    sweep_literal(zeros, "sweep_err");
    pulse_start();
    chk("err_cleared", 32'(Error), 32'd0);
    for (int i = 0; i < DEPTH; i++) push(img_a[i], 0);
    push(12'h008, 0);
    chk("reload_run", 32'(Run), 32'd1);

    // Gappy load of alternating A5A/5A5.
    load_image(img_b, xor_of(img_b), 50);
    chk("gap_run", 32'(Run), 32'd1);
    chk("gap_count", 32'(Word_Count), 32'd8);
    sweep_literal(img_b, "sweep_b");

    // Abort after 5 words with a coincident 0xFFF transfer.
    pulse_start();
    for (int i = 0; i < 5; i++) push(img_a[i], 0);
    Start = 1'b1; Wr_Valid = 1'b1; Wr_Data = 12'hFFF;
    tick();
    Start = 1'b0; Wr_Valid = 1'b0;
    chk("abort_count", 32'(Word_Count), 32'd0);
    for (int i = 0; i < DEPTH; i++) push(img_b[i], 30);
    push(xor_of(img_b), 30);
    chk("abort_reload_run", 32'(Run), 32'd1);
    sweep_literal(img_b, "sweep_abort");

    // Restart from DONE with a new image.
    pulse_start();
    chk("restart_run", 32'(Run), 32'd0);
    chk("restart_ready", 32'(Wr_Ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) push(~img_a[i], 0);
    push(xor_of(img_a) ^ ((DEPTH % 2 == 1) ? 12'hFFF : 12'h000), 0);
    chk("new_img_run", 32'(Run), 32'd1);
    for (int i = 0; i < DEPTH; i++) img_a[i] = ~img_a[i];
    sweep_literal(img_a, "sweep_new");

    // Random images with random gaps; sometimes a corrupted checksum.
    for (int r = 0; r < 12; r++) begin
      logic [WORD_W-1:0] img [DEPTH];
      logic [WORD_W-1:0] cs;
      for (int i = 0; i < DEPTH; i++) img[i] = WORD_W'($urandom);
      cs = xor_of(img);
      if ($urandom_range(3) == 0) cs ^= WORD_W'($urandom_range(4095, 1));
      load_image(img, cs, $urandom_range(60));
      repeat ($urandom_range(3)) tick();
    end

    // Async reset mid-load after 3 words.
    pulse_start();
    for (int i = 0; i < 3; i++) push(img_a[i], 0);
    chk("pre_reset_count", 32'(Word_Count), 32'd3);
    #1;
    Reset = 1'b0;
    #1;
    chk("async_busy", 32'(Busy), 32'd0);
    chk("async_run", 32'(Run), 32'd0);
    chk("async_ready", 32'(Wr_Ready), 32'd0);
    chk("async_count", 32'(Word_Count), 32'd0);
    tick();
    Reset = 1'b1;
    Wr_Valid = 1'b1;
    repeat (3) tick();
    chk("idle_ready", 32'(Wr_Ready), 32'd0);
    Wr_Valid = 1'b0;
    load_image(img_a, xor_of(img_a), 20);
    chk("final_run", 32'(Run), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
